// File: rtl/mm_result_collector.sv
// Per-lane result capture, vector assembly and valid/ready output stage.
// Define MM_COLLECT_ERR_EN to enable the sticky lane-collision err flag.
module mm_result_collector #(
    parameter int N     = 16,
    parameter int DW    = 32,
    parameter int ROWS  = 16,
    parameter int ROW_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW*N-1:0] lane_data,
    input  logic [N-1:0]    lane_valid,
    output logic [DW*N-1:0] out_vector,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic            out_last,
    output logic            busy,
    output logic            err
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [N-1:0]     mask_q, mask_d;
    logic [DW*N-1:0]  buf_q, buf_d;
    logic [DW*N-1:0]  vec_q, vec_d;
    logic             valid_q, valid_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             busy_q, busy_d;

    logic complete;
    logic slot_free;
    logic handshake;
    logic drain;

    always_comb begin
        complete  = &(mask_q | lane_valid);
        slot_free = !valid_q || out_ready;
        handshake = valid_q && out_ready;
        drain     = complete && slot_free;

        mask_d  = mask_q;
        buf_d   = buf_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        row_d   = row_q;

        if (handshake) begin
            valid_d = 1'b0;
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end

        if (drain) begin
            valid_d = 1'b1;
            // Lanes already held for this vector re-arriving start the next one
            mask_d  = lane_valid & mask_q;
        end

        for (int i = 0; i < N; i++) begin
            if (drain) begin
                vec_d[i*DW +: DW] = mask_q[i] ? buf_q[i*DW +: DW]
                                              : lane_data[i*DW +: DW];
                if (lane_valid[i] && mask_q[i]) begin
                    buf_d[i*DW +: DW] = lane_data[i*DW +: DW];
                end
            end else if (lane_valid[i] && !mask_q[i]) begin
                buf_d[i*DW +: DW] = lane_data[i*DW +: DW];
                mask_d[i]         = 1'b1;
            end
        end

        busy_d = (&mask_d) && valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            buf_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            row_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            buf_q   <= buf_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MM_COLLECT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (|(lane_valid & mask_q & {N{!drain}}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_vector = vec_q;
    assign out_valid  = valid_q;
    assign out_row    = row_q;
    assign out_last   = valid_q && (row_q == LAST_ROW);
    assign busy       = busy_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Randomized and directed checks of mm_result_collector against a
// lane-level behavioural model held in arrays.
module tb_mm_result_collector;

    localparam int N     = 16;
    localparam int DW    = 32;
    localparam int ROWS  = 16;
    localparam int ROW_W = 4;

    logic              clk;
    logic              rst;
    logic [DW*N-1:0]   lane_data;
    logic [N-1:0]      lane_valid;
    logic [DW*N-1:0]   out_vector;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;
    logic              busy;
    logic              err;

    int n_cmp;
    int n_bad;

    mm_result_collector #(
        .N(N), .DW(DW), .ROWS(ROWS), .ROW_W(ROW_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lane_data(lane_data),
        .lane_valid(lane_valid),
        .out_vector(out_vector),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row(out_row),
        .out_last(out_last),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which lanes the vector being filled already has,
    // their values, and the vector currently offered to the consumer.
    bit              m_have[N];
    logic [DW-1:0]   m_dat[N];
    bit              m_ov;
    logic [DW-1:0]   m_out[N];
    int              m_row;
    bit              m_busy;
    bit              m_err;

    function automatic logic [DW*N-1:0] exp_vec();
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_out[i];
        return v;
    endfunction

    function automatic bit exp_last();
        return m_ov && (m_row == ROWS - 1);
    endfunction

    task automatic model_update();
        bit all_in;
        bit taken;
        bit room;
        bit full;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_have[i] = 0;
                m_dat[i]  = '0;
                m_out[i]  = '0;
            end
            m_ov = 0; m_row = 0; m_busy = 0; m_err = 0;
            return;
        end
        all_in = 1;
        for (int i = 0; i < N; i++)
            if (!m_have[i] && !lane_valid[i]) all_in = 0;
        taken = m_ov && out_ready;
        room  = !m_ov || out_ready;
        if (taken) m_row = (m_row + 1) % ROWS;
        if (all_in && room) begin
            for (int i = 0; i < N; i++) begin
                m_out[i] = m_have[i] ? m_dat[i] : lane_data[i*DW +: DW];
                // A held lane arriving again belongs to the next vector
                m_have[i] = m_have[i] && lane_valid[i];
                if (m_have[i]) m_dat[i] = lane_data[i*DW +: DW];
            end
            m_ov = 1;
        end else begin
            if (taken) m_ov = 0;
            for (int i = 0; i < N; i++) begin
                if (lane_valid[i]) begin
                    if (m_have[i]) begin
`ifdef MM_COLLECT_ERR_EN
                        m_err = 1;
`endif
                    end else begin
                        m_have[i] = 1;
                        m_dat[i]  = lane_data[i*DW +: DW];
                    end
                end
            end
        end
        full = 1;
        for (int i = 0; i < N; i++) if (!m_have[i]) full = 0;
        m_busy = full && m_ov;
    endtask

    task automatic step(input logic [N-1:0] lv, input logic rdy);
        lane_valid = lv;
        out_ready  = rdy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        lane_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic fill_data(input int base);
        for (int i = 0; i < N; i++) lane_data[i*DW +: DW] = DW'(base + i);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got %b want 0", out_valid);
        end
        if (out_vector !== '0) begin
            n_bad++; $display("FAIL reset_vector got %h want 0", out_vector);
        end
        if (out_row !== '0) begin
            n_bad++; $display("FAIL reset_row got %0d want 0", out_row);
        end
        if (out_last !== 1'b0) begin
            n_bad++; $display("FAIL reset_last got %b want 0", out_last);
        end
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got %b want 0", busy);
        end
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err got %b want 0", err);
        end
    endtask

    task automatic test_single();
        logic [DW*N-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) want[i*DW +: DW] = DW'(32'h100 + i);
        fill_data(32'h100);
        step('1, 1'b1);
        n_cmp += 3;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_valid got %b want 1", out_valid);
        end
        if (out_vector !== want) begin
            n_bad++; $display("FAIL single_vec got %h want %h", out_vector, want);
        end
        if (out_row !== '0) begin
            n_bad++; $display("FAIL single_row got %0d want 0", out_row);
        end
        step('0, 1'b1);
        n_cmp += 2;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_drain got %b want 0", out_valid);
        end
        if (out_row !== ROW_W'(m_row)) begin
            n_bad++; $display("FAIL single_row2 got %0d want %0d", out_row, m_row);
        end
    endtask

    task automatic test_split();
        do_reset();
        fill_data(32'h200);
        step(16'h00ff, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL split_early c%0d got %b want 0", c, out_valid);
            end
            fill_data(32'h300);
            step((c == 3) ? 16'hff00 : 16'h0000, 1'b1);
        end
        n_cmp += 2;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL split_valid got %b want 1", out_valid);
        end
        if (out_vector !== exp_vec()) begin
            n_bad++; $display("FAIL split_vec got %h want %h", out_vector, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [DW*N-1:0] va;
        logic [DW*N-1:0] vb;
        do_reset();
        fill_data(32'hA000);
        va = lane_data;
        step('1, 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL bp_busy_a got %b want 0", busy);
        end
        fill_data(32'hB000);
        vb = lane_data;
        step('1, 1'b0);
        n_cmp += 2;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL bp_busy_b got %b want 1", busy);
        end
        if (out_vector !== va) begin
            n_bad++; $display("FAIL bp_hold_a got %h want %h", out_vector, va);
        end
        step('0, 1'b1);
        n_cmp += 3;
        if (out_vector !== vb) begin
            n_bad++; $display("FAIL bp_vec_b got %h want %h", out_vector, vb);
        end
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL bp_busy_drop got %b want 0", busy);
        end
        if (out_row !== ROW_W'(1)) begin
            n_bad++; $display("FAIL bp_row got %0d want 1", out_row);
        end
        step('0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_empty got %b want 0", out_valid);
        end
    endtask

    task automatic test_rows();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            fill_data(k * 32'h40);
            step('1, 1'b1);
            n_cmp += 3;
            if (out_row !== ROW_W'(k % ROWS)) begin
                n_bad++; $display("FAIL rows_row k%0d got %0d want %0d", k, out_row, k % ROWS);
            end
            if (out_last !== (k == ROWS - 1)) begin
                n_bad++; $display("FAIL rows_last k%0d got %b", k, out_last);
            end
            if (out_vector !== exp_vec()) begin
                n_bad++; $display("FAIL rows_vec k%0d got %h want %h", k, out_vector, exp_vec());
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] lane3;
        bit want_err;
`ifdef MM_COLLECT_ERR_EN
        want_err = 1;
`else
        want_err = 0;
`endif
        do_reset();
        fill_data(32'h500);
        lane_data[3*DW +: DW] = 32'hAA;
        step(16'h000f, 1'b1);
        lane_data[3*DW +: DW] = 32'hBB;
        step(16'h0008, 1'b1);
        fill_data(32'h600);
        step(16'hfff0, 1'b1);
        lane3 = out_vector[3*DW +: DW];
        n_cmp += 3;
        if (lane3 !== 32'hAA) begin
            n_bad++; $display("FAIL coll_lane3 got %h want aa", lane3);
        end
        if (err !== want_err) begin
            n_bad++; $display("FAIL coll_err got %b want %b", err, want_err);
        end
        if (out_vector !== exp_vec()) begin
            n_bad++; $display("FAIL coll_vec got %h want %h", out_vector, exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step('0, 1'b1);
        step('0, 1'b1);
        fill_data(32'h700);
        step(16'h001f, 1'b1);
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mrst_valid got %b want 0", out_valid);
        end
        fill_data(32'h800);
        step('1, 1'b1);
        n_cmp += 3;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL mrst_out got %b want 1", out_valid);
        end
        if (out_row !== '0) begin
            n_bad++; $display("FAIL mrst_row got %0d want 0", out_row);
        end
        if (out_vector !== exp_vec()) begin
            n_bad++; $display("FAIL mrst_vec got %h want %h", out_vector, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [N-1:0] lv;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                lane_data[i*DW +: DW] = $urandom;
                lv[i] = ($urandom_range(0, 9) < 6);
            end
            rst = ($urandom_range(0, 99) == 0);
            step(lv, ($urandom_range(0, 9) < 7));
            rst = 1'b0;
            n_cmp += 6;
            if (out_valid !== m_ov) begin
                n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, out_valid, m_ov);
            end
            if (out_vector !== exp_vec()) begin
                n_bad++; $display("FAIL rnd_vec c%0d got %h want %h", c, out_vector, exp_vec());
            end
            if (out_row !== ROW_W'(m_row)) begin
                n_bad++; $display("FAIL rnd_row c%0d got %0d want %0d", c, out_row, m_row);
            end
            if (out_last !== exp_last()) begin
                n_bad++; $display("FAIL rnd_last c%0d got %b want %b", c, out_last, exp_last());
            end
            if (busy !== m_busy) begin
                n_bad++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, m_busy);
            end
            if (err !== m_err) begin
                n_bad++; $display("FAIL rnd_err c%0d got %b want %b", c, err, m_err);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        lane_data  = '0;
        lane_valid = '0;
        out_ready  = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_backpressure();
        test_rows();
        test_collision();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
